// File: rtl/key_schedule192_ctrl_if.sv
// Handshake and data bundle between a key loader / round-key consumer and the
// AES-192 key-schedule controller.
//   start, key      : expansion request and 192-bit cipher key (w0 in [191:160])
//   busy, done      : controller status, done is a one-cycle completion pulse
//   rk_valid/ready  : round-key stream handshake
//   rk_index        : round-key number 0..12
//   rk_data         : round key, first word in [127:96]
// The master modport is the loader/consumer side; the slave modport is the controller.
interface key_schedule192_ctrl_if;
    logic         start;
    logic [191:0] key;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] rk_data;

    modport master (
        output start, key, rk_ready,
        input  busy, done, rk_valid, rk_index, rk_data
    );

    modport slave (
        input  start, key, rk_ready,
        output busy, done, rk_valid, rk_index, rk_data
    );
endinterface

// File: rtl/key_schedule192_ctrl.sv
// AES-192 key-schedule controller. Expands a 192-bit cipher key one 6-word block per
// cycle, repacks the words into 4-word round keys and streams all 13 of them in order
// over a valid/ready port.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of key_schedule192_ctrl_if (start/key in, busy/done status out,
//           rk_valid/rk_ready/rk_index/rk_data round-key stream)
module key_schedule192_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    key_schedule192_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t       state;
    logic [191:0] cur;    // last expansion block, w[i-6]..w[i-1]
    logic [287:0] wbuf;   // 9-word buffer, oldest word in [287:256]
    logic [3:0]   cnt;    // valid words in wbuf
    logic [3:0]   step;   // expansions done
    logic [3:0]   idx;    // round keys emitted
    logic         busy;
    logic         done;

    logic [191:0] nxt;
    logic [7:0]   rc;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-192 expansion step on the current block.
    always_comb begin
        logic [31:0] t;
        logic [31:0] nw [6];
        rc = 8'(8'h01 << step[2:0]);
        t  = sub_word({cur[23:0], cur[31:24]}) ^ {rc, 24'h0};
        nw[0] = cur[191:160] ^ t;
        for (int i = 1; i < 6; i++) begin
            nw[i] = cur[191-32*i -: 32] ^ nw[i-1];
        end
        nxt = {nw[0], nw[1], nw[2], nw[3], nw[4], nw[5]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            cur   <= '0;
            wbuf  <= '0;
            cnt   <= '0;
            step  <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        cur   <= bus.key;
                        wbuf  <= {bus.key, 96'h0};
                        cnt   <= 4'd6;
                        step  <= 4'd0;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (cnt >= 4'd4) begin
                        if (bus.rk_ready) begin
                            wbuf <= wbuf << 128;
                            cnt  <= cnt - 4'd4;
                            idx  <= idx + 4'd1;
                            if (idx == 4'd12) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= StFin;
                            end
                        end
                    end else if (step < 4'd8) begin
                        // At most 3 words remain here, so the 6 new words always fit.
                        cur  <= nxt;
                        wbuf <= wbuf | ({nxt, 96'h0} >> {cnt, 5'b0});
                        cnt  <= cnt + 4'd6;
                        step <= step + 4'd1;
                    end
                end
                StFin: begin
                    cnt   <= 4'd0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rk_valid = (state == StRun) && (cnt >= 4'd4);
    assign bus.rk_index = idx;
    assign bus.rk_data  = wbuf[287:160];

endmodule

// File: tb/tb_key_schedule192_ctrl.sv
module tb_key_schedule192_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    key_schedule192_ctrl_if bus ();

    key_schedule192_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [191:0] FipsKey = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    logic [7:0]   sb [256];
    logic [127:0] ref_rk [13];
    logic [127:0] got_rk [13];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // S-box from the generator-3 walk over GF(2^8) with its inverse tracked alongside.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Textbook word-array key expansion, then slice into 4-word round keys.
    task automatic build_ref(input logic [191:0] k);
        logic [31:0] w [52];
        logic [31:0] t;
        logic [7:0]  rcv;
        for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
        rcv = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcv, 24'h0};
                rcv = {rcv[6:0], 1'b0};
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [191:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_seq(input logic [191:0] k, input bit rnd_ready, input bit inject,
                           input int abort_at, input bit chain_out,
                           input logic [191:0] next_k, input bit chained_in);
        int           waits;
        int           n;
        int           stalls;
        bit           stalled;
        bit           finished;
        logic [127:0] pd;
        logic [3:0]   pi;
        build_ref(k);
        if (!chained_in) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.key   = k;
        end
        waits = 0;
        while (waits < 4) begin
            @(posedge clk);
            #1;
            waits++;
            if (bus.busy === 1'b1) break;
        end
        chk("accept_cycle", waits, chained_in ? 2 : 1);
        n = 0; stalls = 0; stalled = 0; finished = 0; pd = '0; pi = '0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            bus.start    = inject && (c == 5 || c == 15);
            bus.key      = rnd_key();
            bus.rk_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (c == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", bus.busy, 0);
                chk("rst_valid", bus.rk_valid, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_index", bus.rk_index, 0);
                chk("rst_data", bus.rk_data, 0);
                @(negedge clk);
                reset = 1'b0;
                bus.start = 1'b0;
                bus.rk_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_valid", bus.rk_valid, 0);
                    chk("post_rst_busy", bus.busy, 0);
                end
                return;
            end
            if (c == 1) begin
                chk("c1_busy", bus.busy, 1);
                chk("c1_valid", bus.rk_valid, 1);
            end
            if (stalled) begin
                chk("stall_valid", bus.rk_valid, 1);
                chk("stall_data", bus.rk_data, pd);
                chk("stall_index", bus.rk_index, pi);
            end
            if (bus.done === 1'b1) begin
                chk("done_cycle", c, 22 + stalls);
                chk("done_valid", bus.rk_valid, 0);
                chk("done_busy", bus.busy, 0);
                chk("done_count", n, 13);
                finished = 1;
                if (chain_out) begin
                    bus.start = 1'b1;
                    bus.key   = next_k;
                end
                break;
            end
            stalled = 0;
            if (bus.rk_valid === 1'b1) begin
                if (bus.rk_ready) begin
                    if (n < 13) begin
                        chk("rk_index", bus.rk_index, n);
                        chk("rk_data", bus.rk_data, ref_rk[n]);
                        got_rk[n] = bus.rk_data;
                    end else begin
                        chk("extra_rk", n, 12);
                    end
                    n++;
                end else begin
                    stalled = 1;
                    stalls++;
                    pd = bus.rk_data;
                    pi = bus.rk_index;
                end
            end
        end
        chk("finished", finished, 1);
    endtask

    initial begin
        logic [191:0] k1;
        logic [191:0] k2;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.key = '0;
        bus.rk_ready = 1'b0;
        build_sbox();
        repeat (2) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_valid", bus.rk_valid, 0);
        chk("reset_index", bus.rk_index, 0);
        chk("reset_data", bus.rk_data, 0);
        reset = 1'b0;

        // Known-answer run with the consumer always ready.
        run_seq(FipsKey, 0, 0, 0, 0, '0, 0);
        chk("fips_rk0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("fips_rk1", got_rk[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        chk("fips_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        // Back-pressure from a randomly stalling consumer.
        run_seq(FipsKey, 1, 0, 0, 0, '0, 0);

        // Extra start pulses with other keys while running.
        run_seq(FipsKey, 0, 1, 0, 0, '0, 0);

        // All-zero key.
        run_seq('0, 1, 0, 0, 0, '0, 0);
        chk("zero_rk1", got_rk[1], 128'h00000000000000006263636362636363);

        // Reset in the middle of a run, then a clean run.
        run_seq(rnd_key(), 0, 0, 10, 0, '0, 0);
        run_seq(rnd_key(), 1, 0, 0, 0, '0, 0);

        // Back-to-back runs: second start held from the done cycle.
        k1 = rnd_key();
        k2 = rnd_key();
        run_seq(k1, 0, 0, 0, 1, k2, 0);
        run_seq(k2, 0, 0, 0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
